logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pkg.sv | 48 ++++
 rtl/logic_unit_fifo.sv | 74 +++++++
 rtl/logic_unit_pipe.sv | 167 ++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the pipelined logic unit:
//   - 3-bit operation codes (OP_AND .. OP_PASSX)
//   - FSM state encoding for the accumulate controller
//   - apply_op(): bitwise evaluation of one operation at up to MAX_W bits
// No ports (package).
// ---------------------------------------------------------------------------
package logic_unit_pkg;

    // Widest operand apply_op can evaluate; callers size-cast the result
    // down to their own WIDTH. Every op is bitwise, so the upper bits never
    // affect the lower ones.
    localparam int MAX_W = 64;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NAND  = 3'b011;
    localparam logic [2:0] OP_NOR   = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_ANDN  = 3'b110;
    localparam logic [2:0] OP_PASSX = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Evaluates "a op b" bit by bit. ANDN is a & ~b; PASSX returns a.
    function automatic logic [MAX_W-1:0] apply_op(
        input logic [2:0]       op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        case (op)
            OP_AND:  apply_op = a & b;
            OP_OR:   apply_op = a | b;
            OP_XOR:  apply_op = a ^ b;
            OP_NAND: apply_op = ~(a & b);
            OP_NOR:  apply_op = ~(a | b);
            OP_XNOR: apply_op = ~(a ^ b);
            OP_ANDN: apply_op = a & ~b;
            default: apply_op = a;
        endcase
    endfunction

endpackage

// File: rtl/logic_unit_fifo.sv
// ---------------------------------------------------------------------------
// logic_unit_fifo
// DEPTH-entry synchronous FIFO holding packed result entries.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears pointers, count, storage)
//   i_push   in   write i_data this cycle (ignored when full)
//   i_data   in   entry to write
//   i_pop    in   retire the head entry this cycle (ignored when empty)
//   o_data   out  head entry
//   o_empty  out  no entries stored
//   o_full   out  DEPTH entries stored
// ---------------------------------------------------------------------------
module logic_unit_fifo
    import logic_unit_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Storage, pointers and occupancy. DEPTH is a power of two, so the
    // pointers wrap naturally. A simultaneous push and pop leaves the count
    // unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
// Clocked bitwise logic unit with an accumulate mode and a DEPTH-entry
// output buffer, valid/ready on both sides.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    input handshake
//   in_x, in_y             WIDTH-bit operands
//   in_op                  operation select (see logic_unit_pkg)
//   in_acc, in_last        beat belongs to a group / closes the group
//   out_valid / out_ready  output handshake
//   out_result             result at buffer head
//   out_op                 op of the beat that produced the result
//   out_beats              beats folded into the result (saturating)
//   out_zero               head result is zero (0 when buffer empty)
//   out_err                one-cycle pulse when a group is aborted
// ---------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_zero,
    output logic             out_err
);

    localparam int ENTRY_W = WIDTH + 3 + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             r_state;
    state_e             w_stateNext;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_accNext;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic [CNT_W-1:0]   w_cntInc;
    logic               r_err;
    logic               w_errNext;

    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic [WIDTH-1:0]   w_pushRes;
    logic [CNT_W-1:0]   w_pushBeats;
    logic [WIDTH-1:0]   w_singleRes;
    logic [WIDTH-1:0]   w_foldRes;
    logic [ENTRY_W-1:0] w_headEntry;
    logic               w_empty;
    logic               w_full;

    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // Two candidate results: a fresh X op Y for single beats / group starts,
    // and acc op Y for continuing beats, where X is deliberately ignored.
    assign w_singleRes = WIDTH'(apply_op(in_op, MAX_W'(in_x), MAX_W'(in_y)));
    assign w_foldRes   = WIDTH'(apply_op(in_op, MAX_W'(r_acc), MAX_W'(in_y)));
    assign w_cntInc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    // State register plus the accumulator, beat counter and abort pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_acc   <= w_accNext;
            r_cnt   <= w_cntNext;
            r_err   <= w_errNext;
        end
    end

    // Next-state and push decode. Nothing changes without an accept. A
    // single beat arriving while a group is open aborts the group: the
    // partial accumulation is dropped, out_err pulses, and the beat itself
    // still produces its own single-beat result.
    always_comb begin
        w_stateNext = r_state;
        w_accNext   = r_acc;
        w_cntNext   = r_cnt;
        w_errNext   = 1'b0;
        w_push      = 1'b0;
        w_pushRes   = w_singleRes;
        w_pushBeats = CNT_ONE;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_acc && !in_last) begin
                        w_accNext   = w_singleRes;
                        w_cntNext   = CNT_ONE;
                        w_stateNext = ST_ACCUM;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    if (in_acc) begin
                        if (in_last) begin
                            w_push      = 1'b1;
                            w_pushRes   = w_foldRes;
                            w_pushBeats = w_cntInc;
                            w_accNext   = '0;
                            w_cntNext   = '0;
                            w_stateNext = ST_IDLE;
                        end else begin
                            w_accNext = w_foldRes;
                            w_cntNext = w_cntInc;
                        end
                    end else begin
                        w_errNext   = 1'b1;
                        w_push      = 1'b1;
                        w_accNext   = '0;
                        w_cntNext   = '0;
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    logic_unit_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({w_pushRes, in_op, w_pushBeats}),
        .i_pop   (w_pop),
        .o_data  (w_headEntry),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // in_ready looks only at the registered occupancy, so a full buffer
    // refuses input even in a cycle where the consumer pops.
    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_result = w_headEntry[ENTRY_W-1 -: WIDTH];
    assign out_op     = w_headEntry[CNT_W +: 3];
    assign out_beats  = w_headEntry[CNT_W-1:0];
    assign out_zero   = out_valid && (out_result == '0);
    assign out_err    = r_err;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
// Self-checking bench for logic_unit_pipe (WIDTH=8, DEPTH=2, CNT_W=2).
// A reference model of queued results is updated every falling edge from
// the handshake activity and compared with the DUT outputs; directed
// scenarios add explicit expected values on top.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_op;
    logic [CNT_W-1:0] out_beats;
    logic             out_zero;
    logic             out_err;

    int vecCount  = 0;
    int missCount = 0;

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_beats  (out_beats),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every comparison, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [WIDTH-1:0] res;
        logic [2:0]       op;
        int               beats;
    } entry_t;

    entry_t           expQ[$];
    bit               inGroup    = 0;
    logic [WIDTH-1:0] groupAcc   = '0;
    int               groupBeats = 0;
    bit               errPending = 0;

    function automatic logic [WIDTH-1:0] refOp(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    function automatic void modelPush(input logic [WIDTH-1:0] r,
                                      input logic [2:0] op, input int beats);
        entry_t e;
        e.res   = r;
        e.op    = op;
        e.beats = (beats > CNT_SAT) ? CNT_SAT : beats;
        expQ.push_back(e);
    endfunction

    // Applies the group rules to one accepted beat.
    function automatic void modelAccept();
        logic [WIDTH-1:0] r;
        if (!inGroup) begin
            r = refOp(in_op, in_x, in_y);
            if (in_acc && !in_last) begin
                inGroup    = 1;
                groupAcc   = r;
                groupBeats = 1;
            end else begin
                modelPush(r, in_op, 1);
            end
        end else if (in_acc) begin
            r = refOp(in_op, groupAcc, in_y);
            groupBeats = groupBeats + 1;
            if (in_last) begin
                modelPush(r, in_op, groupBeats);
                inGroup = 0;
            end else begin
                groupAcc = r;
            end
        end else begin
            errPending = 1;
            inGroup    = 0;
            modelPush(refOp(in_op, in_x, in_y), in_op, 1);
        end
    endfunction

    // Falling-edge monitor: compare the DUT with the model, then advance the
    // model by whatever handshakes will complete on the coming rising edge.
    always @(negedge clk) begin
        bit canAccept;
        bit willPop;
        if (!rst_n) begin
            expQ.delete();
            inGroup    = 0;
            errPending = 0;
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
            checkOutput("rst_out_err", 32'(out_err), 32'd0);
        end else begin
            checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
            checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < DEPTH));
            checkOutput("out_err", 32'(out_err), 32'(errPending));
            if (expQ.size() != 0) begin
                checkOutput("out_result", 32'(out_result), 32'(expQ[0].res));
                checkOutput("out_op", 32'(out_op), 32'(expQ[0].op));
                checkOutput("out_beats", 32'(out_beats), 32'(expQ[0].beats));
                checkOutput("out_zero", 32'(out_zero), 32'(expQ[0].res == '0));
            end else begin
                checkOutput("out_zero_empty", 32'(out_zero), 32'd0);
            end
            errPending = 0;
            canAccept  = (expQ.size() < DEPTH);
            willPop    = out_ready && (expQ.size() != 0);
            if (willPop) void'(expQ.pop_front());
            if (in_valid && canAccept) modelAccept();
        end
    end

    // ---------------- stimulus ----------------
    task automatic syncEdge();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and holds it until accepted; returns 1 ns after the
    // accepting edge, so back-to-back calls give one beat per cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y,
                                 input logic [2:0] op,
                                 input logic acc, input logic last);
        bit taken = 0;
        in_x     = x;
        in_y     = y;
        in_op    = op;
        in_acc   = acc;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            syncEdge();
        end
        if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_x     = WIDTH'($urandom);
        in_y     = WIDTH'($urandom);
        in_op    = 3'($urandom);
        in_acc   = 1'($urandom);
        in_last  = 1'($urandom);
    endtask

    // Waits (bounded) for the next valid head and checks it against a
    // literal expected value; ends aligned 1 ns after a rising edge.
    task automatic waitResult(input string tag, input logic [WIDTH-1:0] res,
                              input int beats);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, "_res"}, 32'(out_result), 32'(res));
            checkOutput({tag, "_beats"}, 32'(out_beats), 32'(beats));
        end
        syncEdge();
    endtask

    bit randDone;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_op     = '0;
        in_acc    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        randDone  = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        syncEdge();

        // Narrow single beats (2-bit patterns in the low bits)
        applyStimulus(8'h00, 8'h02, 3'd0, 1'b0, 1'b0);
        applyStimulus(8'h02, 8'h02, 3'd1, 1'b0, 1'b0);
        applyStimulus(8'h02, 8'h01, 3'd2, 1'b0, 1'b0);
        applyStimulus(8'h03, 8'h01, 3'd0, 1'b0, 1'b0);
        waitResult("single_last", 8'h01, 1);

        // Accumulate chain: F0&3C=30, |0F=3F, ^FF=C0
        applyStimulus(8'hF0, 8'h3C, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'h77, 8'h0F, 3'd1, 1'b1, 1'b0);
        applyStimulus(8'h99, 8'hFF, 3'd2, 1'b1, 1'b1);
        waitResult("acc_chain", 8'hC0, 3);

        // Backpressure: two accepted, third refused while full
        out_ready = 1'b0;
        applyStimulus(8'h11, 8'h22, 3'd1, 1'b0, 1'b0);
        applyStimulus(8'hF0, 8'h0F, 3'd0, 1'b0, 1'b0);
        in_x = 8'hAA; in_y = 8'h0F; in_op = 3'd2; in_acc = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_res", 32'(out_result), 32'h33);
            syncEdge();
        end
        out_ready = 1'b1;
        applyStimulus(8'hAA, 8'h0F, 3'd2, 1'b0, 1'b0);
        waitResult("bp_third", 8'hA5, 1);

        // Abort: open group then a single beat
        applyStimulus(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'hAA, 8'h55, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("abort_err", 32'(out_err), 32'd1);
        checkOutput("abort_res", 32'(out_result), 32'h00);
        checkOutput("abort_zero", 32'(out_zero), 32'd1);
        @(negedge clk);
        checkOutput("abort_err_end", 32'(out_err), 32'd0);
        syncEdge();

        // Async reset mid-group
        applyStimulus(8'h0F, 8'hF0, 3'd1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_grp_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_grp_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        syncEdge();

        // Async reset with two buffered entries
        out_ready = 1'b0;
        applyStimulus(8'h01, 8'h02, 3'd1, 1'b0, 1'b0);
        applyStimulus(8'h04, 8'h08, 3'd1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_buf_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_buf_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        syncEdge();
        out_ready = 1'b1;
        applyStimulus(8'h12, 8'h21, 3'd1, 1'b0, 1'b0);
        waitResult("post_rst", 8'h33, 1);

        // Beat counter saturation: 5-beat PASSX group
        applyStimulus(8'h5A, 8'h13, 3'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 3'd7, 1'b1, 1'b0);
        applyStimulus(8'hC3, 8'h3C, 3'd7, 1'b1, 1'b1);
        waitResult("sat", 8'h5A, CNT_SAT);

        // Randomized traffic with random consumer backpressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom),
                                  ($urandom_range(0, 1) == 1),
                                  ($urandom_range(0, 3) == 0));
                    if ($urandom_range(0, 4) == 0) syncEdge();
                end
                randDone = 1;
            end
            begin
                while (!randDone) begin
                    syncEdge();
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) syncEdge();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
